// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file access arbiter.
package rf_arb_pkg;

  typedef enum logic {LK_UNLOCKED, LK_LOCKED} lock_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

  localparam int RF_DATA_W       = 16;
  localparam int RF_ADDR_W       = 3;
  localparam int RF_STARVE_LIMIT = 4;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Saturating count of consecutive cycles a pending debug request has lost arbitration.
module rf_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one 2R/1W register file between the core pipeline and the debug unit,
// with debug lock-out of the core and starvation protection for debug requests.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr_a,
  input  logic [ADDR_W-1:0] core_addr_b,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata_a,
  output logic [DATA_W-1:0] core_rdata_b,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr_a,
  input  logic [ADDR_W-1:0] dbg_addr_b,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata_a,
  output logic [DATA_W-1:0] dbg_rdata_b,
  input  logic              dbg_lock,
  output logic              dbg_locked,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_dout_a,
  input  logic [DATA_W-1:0] rf_dout_b
);

  lock_state_t state_q, state_d;
  owner_t      owner;
  logic        at_limit;

  logic              core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0] core_rdata_a_q, core_rdata_a_d, core_rdata_b_q, core_rdata_b_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_a_q, dbg_rdata_a_d, dbg_rdata_b_q, dbg_rdata_b_d;

  // Readies express "would win if valid", so neither depends on the other's ready.
  always_comb begin
    core_ready = 1'b0;
    dbg_ready  = 1'b0;
    owner      = OWN_NONE;
    if (rst_n) begin
      if (state_q == LK_LOCKED) begin
        dbg_ready = 1'b1;
      end else begin
        core_ready = !(at_limit && dbg_valid);
        dbg_ready  = at_limit || !core_valid;
      end
      if (core_valid && core_ready) begin
        owner = OWN_CORE;
      end else if (dbg_valid && dbg_ready) begin
        owner = OWN_DBG;
      end
    end
  end

  always_comb begin
    rf_addr_a = '0;
    rf_addr_b = '0;
    rf_din    = '0;
    rf_write  = 1'b0;
    case (owner)
      OWN_CORE: begin
        rf_addr_a = core_addr_a;
        rf_addr_b = core_addr_b;
        rf_din    = core_wdata;
        rf_write  = core_we;
      end
      OWN_DBG: begin
        rf_addr_a = dbg_addr_a;
        rf_addr_b = dbg_addr_b;
        rf_din    = dbg_wdata;
        rf_write  = dbg_we;
      end
      default: ;
    endcase
  end

  rf_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((owner == OWN_DBG) || !dbg_valid),
    .inc     (dbg_valid && (owner != OWN_DBG) && (state_q == LK_UNLOCKED)),
    .at_limit(at_limit)
  );

  always_comb begin
    state_d        = dbg_lock ? LK_LOCKED : LK_UNLOCKED;
    core_rvalid_d  = (owner == OWN_CORE) && !core_we;
    dbg_rvalid_d   = (owner == OWN_DBG) && !dbg_we;
    core_rdata_a_d = core_rvalid_d ? rf_dout_a : core_rdata_a_q;
    core_rdata_b_d = core_rvalid_d ? rf_dout_b : core_rdata_b_q;
    dbg_rdata_a_d  = dbg_rvalid_d ? rf_dout_a : dbg_rdata_a_q;
    dbg_rdata_b_d  = dbg_rvalid_d ? rf_dout_b : dbg_rdata_b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= LK_UNLOCKED;
      core_rvalid_q  <= 1'b0;
      core_rdata_a_q <= '0;
      core_rdata_b_q <= '0;
      dbg_rvalid_q   <= 1'b0;
      dbg_rdata_a_q  <= '0;
      dbg_rdata_b_q  <= '0;
    end else begin
      state_q        <= state_d;
      core_rvalid_q  <= core_rvalid_d;
      core_rdata_a_q <= core_rdata_a_d;
      core_rdata_b_q <= core_rdata_b_d;
      dbg_rvalid_q   <= dbg_rvalid_d;
      dbg_rdata_a_q  <= dbg_rdata_a_d;
      dbg_rdata_b_q  <= dbg_rdata_b_d;
    end
  end

  assign dbg_locked   = (state_q == LK_LOCKED);
  assign core_rvalid  = core_rvalid_q;
  assign core_rdata_a = core_rdata_a_q;
  assign core_rdata_b = core_rdata_b_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign dbg_rdata_a  = dbg_rdata_a_q;
  assign dbg_rdata_b  = dbg_rdata_b_q;

endmodule
